icc_branch_unit: RTL

Integer condition-code (icc) register and Bicc branch resolver in the EX stage. It sits directly downstream of the 32-bit ALU. It captures the ALU's N/Z/V/C flags when the EX instruction writes the condition codes, and feeds the stored carry back to the ALU as `Ci` for ADDX/SUBX. It also resolves conditional branches waiting in ID against the current icc, stalling ID when a condition-code write has not yet committed.

---
 rtl/sparc_pkg.sv | 44 ++++
 rtl/icc_branch_unit_if.sv | 42 ++++
 rtl/bicc_cond_eval.sv | 39 +++
 rtl/icc_branch_unit.sv | 126 ++++++++++++
 4 files changed

// File: rtl/sparc_pkg.sv
// Shared SPARC integer-unit definitions: Bicc condition encodings, branch
// resolver states and icc bit positions.
package sparc_pkg;

  localparam logic [3:0] COND_BN   = 4'b0000;
  localparam logic [3:0] COND_BE   = 4'b0001;
  localparam logic [3:0] COND_BLE  = 4'b0010;
  localparam logic [3:0] COND_BL   = 4'b0011;
  localparam logic [3:0] COND_BLEU = 4'b0100;
  localparam logic [3:0] COND_BCS  = 4'b0101;
  localparam logic [3:0] COND_BNEG = 4'b0110;
  localparam logic [3:0] COND_BVS  = 4'b0111;
  localparam logic [3:0] COND_BA   = 4'b1000;
  localparam logic [3:0] COND_BNE  = 4'b1001;
  localparam logic [3:0] COND_BG   = 4'b1010;
  localparam logic [3:0] COND_BGE  = 4'b1011;
  localparam logic [3:0] COND_BGU  = 4'b1100;
  localparam logic [3:0] COND_BCC  = 4'b1101;
  localparam logic [3:0] COND_BPOS = 4'b1110;
  localparam logic [3:0] COND_BVC  = 4'b1111;

  localparam int ICC_N = 3;
  localparam int ICC_Z = 2;
  localparam int ICC_V = 1;
  localparam int ICC_C = 0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } br_state_e;

  // Packs separate ALU flag bits into the {N,Z,V,C} icc layout.
  function automatic logic [3:0] pack_icc(input logic n, input logic z,
                                          input logic v, input logic c);
    logic [3:0] f;
    f        = 4'b0000;
    f[ICC_N] = n;
    f[ICC_Z] = z;
    f[ICC_V] = v;
    f[ICC_C] = c;
    return f;
  endfunction

endpackage

// File: rtl/icc_branch_unit_if.sv
// Signal bundle between the EX/ID pipeline control and the icc/branch unit.
interface icc_branch_unit_if;
  import sparc_pkg::*;

  // EX-stage flag source and icc write control
  logic       N_EX;
  logic       Z_EX;
  logic       V_EX;
  logic       C_EX;
  logic       CC_WE;
  logic       EX_HOLD;

  // ID-stage branch request
  logic       BR_REQ;
  logic [3:0] BR_COND;
  logic       BR_A;
  logic       BR_FLUSH;

  // Results. BR_VALID is a single-cycle strobe with no ready: the consumer
  // must take BR_TAKEN/ANNUL_DS in that cycle, they are meaningless otherwise.
  // BR_STALL holds ID; BR_REQ must be held stable while it is high.
  logic [3:0] ICC;
  logic       Ci;
  logic       BR_STALL;
  logic       BR_VALID;
  logic       BR_TAKEN;
  logic       ANNUL_DS;
  br_state_e  dbg_state;

  modport master (
    output N_EX, Z_EX, V_EX, C_EX, CC_WE, EX_HOLD,
    output BR_REQ, BR_COND, BR_A, BR_FLUSH,
    input  ICC, Ci, BR_STALL, BR_VALID, BR_TAKEN, ANNUL_DS, dbg_state
  );

  modport slave (
    input  N_EX, Z_EX, V_EX, C_EX, CC_WE, EX_HOLD,
    input  BR_REQ, BR_COND, BR_A, BR_FLUSH,
    output ICC, Ci, BR_STALL, BR_VALID, BR_TAKEN, ANNUL_DS, dbg_state
  );

endinterface

// File: rtl/bicc_cond_eval.sv
// Combinational Bicc condition evaluator: cond[3] inverts the base test
// selected by cond[2:0], which makes BN/BA the degenerate pair.
module bicc_cond_eval
  import sparc_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic n;
  logic z;
  logic v;
  logic c;
  logic base;

  assign n = flags[ICC_N];
  assign z = flags[ICC_Z];
  assign v = flags[ICC_V];
  assign c = flags[ICC_C];

  always_comb begin
    base = 1'b0;
    case (cond[2:0])
      3'd0:    base = 1'b0;
      3'd1:    base = z;
      3'd2:    base = z | (n ^ v);
      3'd3:    base = n ^ v;
      3'd4:    base = c | z;
      3'd5:    base = c;
      3'd6:    base = n;
      3'd7:    base = v;
      default: base = 1'b0;
    endcase
  end

  assign taken = cond[3] ? ~base : base;

endmodule

// File: rtl/icc_branch_unit.sv
// EX-stage icc register plus Bicc resolver; either forwards EX flags to the
// branch in ID or parks the branch in WAIT until the icc write commits.
module icc_branch_unit
  import sparc_pkg::*;
#(
  parameter bit FWD_CC = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  icc_branch_unit_if.slave bus
);

  logic [3:0] ex_flags;
  logic [3:0] icc_q;
  logic       icc_we;

  br_state_e  state_q;
  br_state_e  state_d;
  logic [3:0] cond_q;
  logic       a_q;
  logic       latch;
  logic       resolve;
  logic       stall;

  logic [3:0] eval_cond;
  logic [3:0] eval_flags;
  logic       eval_a;
  logic       eval_taken;
  logic       eval_annul;

  logic       valid_q;
  logic       taken_q;
  logic       annul_q;

  assign ex_flags = pack_icc(bus.N_EX, bus.Z_EX, bus.V_EX, bus.C_EX);
  assign icc_we   = bus.CC_WE & ~bus.EX_HOLD;

  // Next-state and evaluation-source selection.
  always_comb begin
    state_d    = state_q;
    latch      = 1'b0;
    resolve    = 1'b0;
    stall      = 1'b0;
    eval_cond  = bus.BR_COND;
    eval_a     = bus.BR_A;
    eval_flags = (FWD_CC && bus.CC_WE) ? ex_flags : icc_q;

    case (state_q)
      IDLE: begin
        if (bus.BR_REQ) begin
          if (FWD_CC || !bus.CC_WE) begin
            resolve = 1'b1;
          end else begin
            latch   = 1'b1;
            stall   = 1'b1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // The parked branch only ever sees committed flags.
        stall      = 1'b1;
        eval_cond  = cond_q;
        eval_a     = a_q;
        eval_flags = icc_q;
        if (!bus.CC_WE) begin
          resolve = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.BR_FLUSH) begin
      state_d = IDLE;
    end
  end

  bicc_cond_eval u_cond_eval (
    .cond  (eval_cond),
    .flags (eval_flags),
    .taken (eval_taken)
  );

  // BA with the annul bit set annuls its delay slot despite being taken.
  assign eval_annul = eval_a & (~eval_taken | (eval_cond == COND_BA));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cond_q  <= 4'b0000;
      a_q     <= 1'b0;
      icc_q   <= 4'b0000;
      valid_q <= 1'b0;
      taken_q <= 1'b0;
      annul_q <= 1'b0;
    end else begin
      if (latch) begin
        cond_q <= bus.BR_COND;
        a_q    <= bus.BR_A;
      end
      if (icc_we) begin
        icc_q <= ex_flags;
      end
      valid_q <= resolve & ~bus.BR_FLUSH;
      taken_q <= resolve & ~bus.BR_FLUSH & eval_taken;
      annul_q <= resolve & ~bus.BR_FLUSH & eval_annul;
    end
  end

  assign bus.ICC       = icc_q;
  assign bus.Ci        = icc_q[ICC_C];
  assign bus.BR_STALL  = stall;
  assign bus.BR_VALID  = valid_q;
  assign bus.BR_TAKEN  = taken_q;
  assign bus.ANNUL_DS  = annul_q;
  assign bus.dbg_state = state_q;

endmodule
